// File: rtl/subset_coord_reader.sv
// Walks a captured set of packed float32 (x, y) coordinates, converts each to integer
// col/row, and hands out row*IMAGE_WIDTH+col linear pixel addresses over a valid/ready port.
module subset_coord_reader #(
  parameter int unsigned NUM_POINTS  = 9,
  parameter int unsigned IMAGE_WIDTH = 640
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [32*NUM_POINTS-1:0] x,
  input  logic [32*NUM_POINTS-1:0] y,
  input  logic                    sub_done,
  input  logic                    addr_ready,
  output logic [31:0]             pixel_addr,
  output logic [15:0]             col,
  output logic [15:0]             row,
  output logic [7:0]              point_idx,
  output logic                    addr_valid,
  output logic                    coord_error,
  output logic                    read_done
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] CAPTURE = 3'd1;
  localparam logic [2:0] CONV    = 3'd2;
  localparam logic [2:0] ADDR    = 3'd3;
  localparam logic [2:0] SEND    = 3'd4;
  localparam logic [2:0] DONE    = 3'd5;

  localparam logic [7:0] LAST_IDX = 8'(NUM_POINTS - 1);

  logic [2:0]              state_q, state_d;
  logic                    sub_done_q;
  logic [32*NUM_POINTS-1:0] x_sh_q, x_sh_d;
  logic [32*NUM_POINTS-1:0] y_sh_q, y_sh_d;
  logic [7:0]              k_q, k_d;
  logic [15:0]             col_q, col_d;
  logic [15:0]             row_q, row_d;
  logic [31:0]             addr_q, addr_d;
  logic                    err_q, err_d;

  logic [31:0]             x_cur, y_cur;
  logic [16:0]             x_conv, y_conv;
  logic [31:0]             addr_calc;
  logic                    sub_done_rise;

  // Returns {error, value}; truncates toward zero, clamps negatives to 0 and overflow to 0xFFFF.
  function automatic logic [16:0] f32_to_u16(input logic [31:0] f);
    logic [7:0]  expo;
    logic [23:0] man;
    logic [7:0]  amt;
    logic [16:0] res;
    expo = f[30:23];
    man  = {1'b1, f[22:0]};
    amt  = 8'd150 - expo;
    if (f[30:0] == 31'd0) begin
      res = 17'd0;
    end else if (f[31]) begin
      res = {1'b1, 16'd0};
    end else if (expo < 8'd127) begin
      res = 17'd0;
    end else if (expo > 8'd142) begin
      res = {1'b1, 16'hFFFF};
    end else begin
      res = {1'b0, 16'(man >> amt)};
    end
    return res;
  endfunction

  always_comb begin
    x_cur = '0;
    y_cur = '0;
    for (int i = 0; i < NUM_POINTS; i++) begin
      if (k_q == 8'(i)) begin
        x_cur = x_sh_q[32*i +: 32];
        y_cur = y_sh_q[32*i +: 32];
      end
    end
  end

  assign x_conv        = f32_to_u16(x_cur);
  assign y_conv        = f32_to_u16(y_cur);
  assign addr_calc     = 32'(row_q) * 32'(IMAGE_WIDTH) + 32'(col_q);
  assign sub_done_rise = sub_done & ~sub_done_q;

  always_comb begin
    state_d = state_q;
    x_sh_d  = x_sh_q;
    y_sh_d  = y_sh_q;
    k_d     = k_q;
    col_d   = col_q;
    row_d   = row_q;
    addr_d  = addr_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (sub_done_rise) state_d = CAPTURE;
      end
      CAPTURE: begin
        x_sh_d  = x;
        y_sh_d  = y;
        err_d   = 1'b0;
        k_d     = 8'd0;
        state_d = CONV;
      end
      CONV: begin
        col_d   = x_conv[15:0];
        row_d   = y_conv[15:0];
        err_d   = err_q | x_conv[16] | y_conv[16];
        state_d = ADDR;
      end
      ADDR: begin
        addr_d  = addr_calc;
        state_d = SEND;
      end
      SEND: begin
        if (addr_ready) begin
          if (k_q < LAST_IDX) begin
            k_d     = k_q + 8'd1;
            state_d = CONV;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      sub_done_q <= 1'b0;
      x_sh_q     <= '0;
      y_sh_q     <= '0;
      k_q        <= 8'd0;
      col_q      <= 16'd0;
      row_q      <= 16'd0;
      addr_q     <= 32'd0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      // Tracked in every state so a level still high on return to IDLE cannot retrigger.
      sub_done_q <= sub_done;
      x_sh_q     <= x_sh_d;
      y_sh_q     <= y_sh_d;
      k_q        <= k_d;
      col_q      <= col_d;
      row_q      <= row_d;
      addr_q     <= addr_d;
      err_q      <= err_d;
    end
  end

  assign pixel_addr  = addr_q;
  assign col         = col_q;
  assign row         = row_q;
  assign point_idx   = k_q;
  assign coord_error = err_q;
  assign addr_valid  = (state_q == SEND);
  assign read_done   = (state_q == DONE);

endmodule

// File: doc/subset_coord_reader.md
SUBSET_COORD_READER -- requirements
Module: subset_coord_reader

Interface
REQ-001 SHALL have parameter NUM_POINTS, default 9, giving the number of packed float32 coordinates per bus.
REQ-002 SHALL have parameter IMAGE_WIDTH, default 640, giving the frame width in pixels used for linear addressing.
REQ-003 SHALL have `clock`, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-004 SHALL have `reset_n`, input, 1 bit: one clock; reset is asynchronous and active-low.
REQ-005 SHALL have `x`, input, 32*NUM_POINTS bits: packed IEEE-754 single column coordinates; point k occupies bits [32k+31:32k].
REQ-006 SHALL have `y`, input, 32*NUM_POINTS bits: packed IEEE-754 single row coordinates, with the same packing as `x`.
REQ-007 SHALL have `sub_done`, input, 1 bit: producer done level; it stays high once the coordinates are valid.
REQ-008 SHALL have `addr_ready`, input, 1 bit: the downstream consumer accepts the current address.
REQ-009 SHALL have `pixel_addr`, output, 32 bits: row*IMAGE_WIDTH+col for the current point.
REQ-010 SHALL have `col`, output, 16 bits, and `row`, output, 16 bits: the integer coordinates of the current point.
REQ-011 SHALL have `point_idx`, output, 8 bits: the index k of the current point.
REQ-012 SHALL have `addr_valid`, output, 1 bit: `pixel_addr`, `col`, `row` and `point_idx` are valid.
REQ-013 SHALL have `coord_error`, output, 1 bit: sticky flag set on any clamped or saturated conversion during the current set.
REQ-014 SHALL have `read_done`, output, 1 bit: one-cycle pulse after the last point is accepted.

Function
REQ-015 SHALL implement FSM states IDLE, CAPTURE, CONV, ADDR, SEND and DONE.
REQ-016 SHALL, in IDLE, detect the rising edge of `sub_done` (registered previous value 0, current value 1); a steady-high level SHALL NOT retrigger.
REQ-017 SHALL, in CAPTURE, latch `x` and `y` into shadow registers, clear `coord_error`, and set k=0; later input changes SHALL NOT affect the current set.
REQ-018 SHALL, in CONV, convert float x[k] to col and float y[k] to row by truncation toward zero.
REQ-019 SHALL apply these conversion rules:
- sign=1 with a nonzero magnitude: result 0, `coord_error` set.
- -0.0 or +0.0: result 0, no error.
- exponent < 127: result 0.
- exponent in 127..142: result = {1,mantissa} >> (150 - exponent), truncated to 16 bits.
- exponent > 142, including Inf/NaN (exponent 255): result 0xFFFF, `coord_error` set.
REQ-020 SHALL, in ADDR, compute pixel_addr = row*IMAGE_WIDTH + col as an unsigned 32-bit result, truncated modulo 2^32.
REQ-021 SHALL, in SEND, assert `addr_valid` and hold `pixel_addr`, `col`, `row` and `point_idx` stable until a cycle in which `addr_ready`=1.
REQ-022 SHALL count a transfer on a clock edge where `addr_valid`=1 and `addr_ready`=1:
- if k < NUM_POINTS-1: increment k and go to CONV, with `addr_valid` low on the next cycle.
- otherwise: go to DONE.
REQ-023 SHALL, in DONE, assert `read_done` for exactly one cycle and then return to IDLE; `coord_error` SHALL hold until the next CAPTURE.
REQ-024 SHALL give a latency of 4 cycles from the sampled `sub_done` rising edge to the first `addr_valid` (IDLE→CAPTURE→CONV→ADDR→SEND).
REQ-025 SHALL take 3 cycles per subsequent point when `addr_ready` is held high.
REQ-026 SHALL ignore `sub_done` while not in IDLE.
REQ-027 SHALL require `sub_done` to fall and rise again for a new set if `sub_done` is still high on return to IDLE.
REQ-028 SHALL handle `addr_ready` high while `addr_valid` is low with no effect.

Reset
REQ-029 SHALL, on `reset_n`=0 at any time, including mid-SEND, immediately force state IDLE, k=0, `addr_valid`=0, `read_done`=0, `coord_error`=0, `pixel_addr`=0, `col`=0, `row`=0, `point_idx`=0, and the `sub_done` edge register to 0.
REQ-030 SHALL, after reset deassertion, start a new set if `sub_done` is already high, because the edge register was reset to 0.

Verification
REQ-031 SHALL be verified by this scenario: x[31:0]=0x41100000 (9.0), y[31:0]=0x41100000, `sub_done` rising, `addr_ready`=1 -> 4 cycles later `addr_valid`=1 with col=9, row=9, pixel_addr=5769, point_idx=0.
REQ-032 SHALL be verified by this scenario: point 1 x=0x40200000 (2.5), y=0x3F000000 (0.5) -> col=2, row=0, pixel_addr=2, `coord_error`=0.
REQ-033 SHALL be verified by this scenario: x=0xBF800000 (-1.0) and y=0x49742400 (1e6) -> col=0, row=65535, pixel_addr=41942400, `coord_error`=1 until the next capture.
REQ-034 SHALL be verified by this scenario: `addr_ready` held low for 5 cycles in SEND -> outputs stable for all 5 cycles, k unchanged, advance one cycle after `addr_ready` rises.
REQ-035 SHALL be verified by this scenario: full set of 9 points, `addr_ready`=1 -> exactly 9 transfers, point_idx 0..8 in order, `read_done` pulses once for 1 cycle, and no restart while `sub_done` stays high.
REQ-036 SHALL be verified by this scenario: `reset_n` pulsed low during SEND of point 4 -> all outputs 0 immediately; with `sub_done` high at release, a new set starts at point_idx=0.
